// File: rtl/ef_pin_in_cond.sv
// Per-pin pad input conditioner: 2-flop sync, optional glitch filter, registered level,
// edge pulses and sticky clearable edge flags. Latency 3 cycles (bypass/N=0), 3+N filtered.
module ef_pin_in_cond #(
  parameter int COUNT = 16,
  parameter int FLT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COUNT-1:0]   pad_in,
  input  logic [COUNT-1:0]   flt_en,
  input  logic [FLT_W-1:0]   flt_len,
  input  logic [2*COUNT-1:0] edge_sel,
  input  logic [COUNT-1:0]   flag_clr,
  output logic [COUNT-1:0]   pin_q,
  output logic [COUNT-1:0]   rise,
  output logic [COUNT-1:0]   fall,
  output logic [COUNT-1:0]   flag
);

  logic [COUNT-1:0] s1_q, s2_q;
  logic [COUNT-1:0] pin_d;
  logic [COUNT-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [COUNT-1:0] flag_q, flag_d, set_d;
  logic [FLT_W-1:0] cnt_q [COUNT];
  logic [FLT_W-1:0] cnt_d [COUNT];

  always_comb begin
    pin_d = pin_q;
    cnt_d = cnt_q;
    set_d = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (!flt_en[i]) begin
        pin_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else if (s2_q[i] == pin_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= flt_len) begin
        // >= so that shrinking flt_len mid-count commits immediately
        pin_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    // Edges come from the next-state level so pulses line up with the new pin_q value
    rise_d = pin_d & ~pin_q;
    fall_d = ~pin_d & pin_q;
    for (int i = 0; i < COUNT; i++) begin
      set_d[i] = (rise_d[i] & edge_sel[2*i]) | (fall_d[i] & edge_sel[2*i+1]);
    end
    flag_d = (flag_q & ~flag_clr) | set_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      pin_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      flag_q <= '0;
      for (int i = 0; i < COUNT; i++) cnt_q[i] <= '0;
    end else begin
      s1_q   <= pad_in;
      s2_q   <= s1_q;
      pin_q  <= pin_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      flag_q <= flag_d;
      for (int i = 0; i < COUNT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
  assign flag = flag_q;

endmodule

// File: tb/tb_ef_pin_in_cond.sv
// Directed self-checking bench for ef_pin_in_cond: reset release, filter qualification,
// mid-count length change, bypass toggling, flag set/clear priority and mid-filter reset.
module tb_ef_pin_in_cond;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pad_in, flt_en, flag_clr;
  logic [3:0]  flt_len;
  logic [31:0] edge_sel;
  logic [15:0] pin_q, rise, fall, flag;

  int n_checks = 0;
  int n_errors = 0;

  ef_pin_in_cond #(.COUNT(16), .FLT_W(4)) dut (
    .clk(clk), .rst(rst), .pad_in(pad_in), .flt_en(flt_en), .flt_len(flt_len),
    .edge_sel(edge_sel), .flag_clr(flag_clr), .pin_q(pin_q), .rise(rise),
    .fall(fall), .flag(flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; outputs are then stable for sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pad_in = '0; flt_en = '0; flt_len = '0; edge_sel = '0; flag_clr = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  logic pat [0:12];

  initial begin
    // Reset release with all pads high and rise flags selected
    rst = 1'b1; pad_in = 16'hFFFF; flt_en = '0; flt_len = '0;
    edge_sel = 32'h5555_5555; flag_clr = '0;
    tick(); tick(); tick();
    check("rst_pin", pin_q, 0);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);
    check("rst_flag", flag, 0);
    rst = 1'b0;
    tick(); check("rel1_pin", pin_q, 0);
    tick(); check("rel2_pin", pin_q, 0);
    tick();
    check("rel3_pin", pin_q, 16'hFFFF);
    check("rel3_rise", rise, 16'hFFFF);
    check("rel3_flag", flag, 16'hFFFF);
    tick();
    check("rel4_rise", rise, 0);
    check("rel4_flag", flag, 16'hFFFF);

    // Pin 0, N=3: 3-cycle pulse suppressed, 4-cycle level accepted at edge k+5
    do_reset();
    flt_en = 16'h0001; flt_len = 4'd3;
    pad_in[0] = 1'b1;
    tick(); tick(); tick();
    pad_in[0] = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tick();
      check("short_pin0", {pin_q[0], rise[0]}, 0);
    end
    pad_in[0] = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      check("long_pin0", pin_q[0], (t == 6));
      check("long_rise0", rise[0], (t == 6));
    end
    tick();
    check("long_rise0_end", rise[0], 0);

    // Pin 1: shrinking flt_len below the running count commits on the next edge
    do_reset();
    flt_en = 16'h0002; flt_len = 4'd10;
    pad_in[1] = 1'b1;
    for (int t = 1; t <= 6; t++) tick();
    check("len_pre_pin1", pin_q[1], 0);
    flt_len = 4'd2;
    tick();
    check("len_post_pin1", pin_q[1], 1);
    check("len_post_rise1", rise[1], 1);

    // Pin 2 bypass: toggling pad shows up 3 edges later with alternating edge pulses
    do_reset();
    for (int e = 0; e <= 12; e++) pat[e] = (e >= 1 && e <= 10) ? e[0] : 1'b0;
    for (int t = 1; t <= 12; t++) begin
      pad_in[2] = pat[t];
      tick();
      if (t >= 3) begin
        check("tog_pin2", pin_q[2], pat[t-2]);
        check("tog_rise2", rise[2], pat[t-2] & ~pat[t-3]);
        check("tog_fall2", fall[2], ~pat[t-2] & pat[t-3]);
      end
    end

    // Pin 3 fall-only flag: set beats a simultaneous clear, then a lone clear wins
    do_reset();
    edge_sel = 32'h0000_0080;
    pad_in[3] = 1'b1;
    tick(); tick(); tick();
    check("fl_pin3", pin_q[3], 1);
    check("fl_rise_noflag3", flag[3], 0);
    pad_in[3] = 1'b0;
    tick(); tick();
    flag_clr[3] = 1'b1;
    tick();
    check("fl_fall3", fall[3], 1);
    check("fl_setwins3", flag[3], 1);
    tick();
    check("fl_clr3", flag[3], 0);
    check("fl_fall3_end", fall[3], 0);
    flag_clr[3] = 1'b0;

    // Reset mid-count on pin 0 (N=5) forces a full requalification afterwards
    do_reset();
    flt_en = 16'h0001; flt_len = 4'd5; edge_sel = 32'h0000_0001;
    pad_in[0] = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("mid_rst_pin", pin_q, 0);
    check("mid_rst_rise", rise, 0);
    check("mid_rst_flag", flag, 0);
    rst = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      check("mid_req_pin0", pin_q[0], (t == 8));
      check("mid_req_flag0", flag[0], (t == 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
